fetch_redirect_unit: RTL and testbench
======================================

FETCH_REDIRECT_UNIT -- requirements
Module: fetch_redirect_unit

Interface
REQ-001 The block SHALL have parameter PC_W, default 9, meaning the width of the program-counter and instruction-address path.
REQ-002 The block SHALL have parameter INSTR_W, default 32, meaning the instruction word width.
REQ-003 The block SHALL have parameter HALT_WORD, default 32'hFFFF_FFFF, meaning the instruction encoding that halts fetch.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port stall, input, 1 bit: decode hazard stall; freezes the fetch path.
REQ-007 The block SHALL have port branch, input, 1 bit: taken-branch indication from the MEM-stage branch decoder.
REQ-008 The block SHALL have port pc_mem_resolved, input, PC_W bits: the branch target, valid when branch=1.
REQ-009 The block SHALL have port imem_addr, output, PC_W bits: the instruction memory word address.
REQ-010 The block SHALL have port imem_en, output, 1 bit: memory read enable; the memory holds imem_rdata when imem_en=0.
REQ-011 The block SHALL have port imem_rdata, input, INSTR_W bits: synchronous-read data for the address presented on the previous enabled cycle.
REQ-012 The block SHALL have ports instr_id (INSTR_W), pc_id (PC_W) and valid_id (1), all outputs: the IF/ID pipeline register contents.
REQ-013 The block SHALL have ports flush_ifid, flush_idex and flush_exmem, all outputs of 1 bit: squash signals for the younger pipeline registers.
REQ-014 The block SHALL have port halted, output, 1 bit: fetch is halted.
REQ-015 The block SHALL have port branch_count, output, 16 bits: the number of taken branches.

Function
REQ-016 The block SHALL hold internal state: PC register P; fetch tag pc_f; fetch-valid flag f_valid; FSM with states BOOT, RUN and HALT.
REQ-017 The block SHALL drive imem_addr = P combinationally.
REQ-018 The block SHALL drive imem_en = ~stall | branch, forced to 0 in HALT unless branch=1.
REQ-019 The block SHALL drive flush_ifid, flush_idex and flush_exmem combinationally equal to branch, in every state including HALT.
REQ-020 The block SHALL update on each edge with branch=1, regardless of stall or state: P<=pc_mem_resolved, f_valid<=0, valid_id<=0, FSM<=RUN.
REQ-021 The block SHALL update on each edge with branch=0, stall=0 and state RUN: P<=P+1, modulo 2^PC_W (511 wraps to 0); pc_f<=P; f_valid<=1; instr_id<=imem_rdata; pc_id<=pc_f; valid_id<=f_valid.
REQ-022 The block SHALL hold P, pc_f, f_valid, instr_id, pc_id and valid_id unchanged on each edge with branch=0 and stall=1.
REQ-023 The block SHALL pass BOOT in exactly one cycle: P<=1, pc_f<=0, f_valid<=1, valid_id stays 0, then go to RUN.
REQ-024 The block SHALL, when RUN captures instr_id==HALT_WORD with f_valid=1, deliver that word with valid_id=1 and enter HALT on the same edge.
REQ-025 The block SHALL, in HALT: freeze P; force valid_id<=0 from the next edge; drive halted=1. Only branch or rst leaves HALT.
REQ-026 The block SHALL meet redirect latency: branch in cycle T -> target on imem_addr in T+1 -> valid_id=1 with pc_id=target in T+3; valid_id=0 in T+1 and T+2.
REQ-027 The block SHALL apply priority branch > stall > halt-detect when these coincide.

Reset
REQ-028 The block SHALL, on rst=1 at an edge, set: P=0; pc_f=0; f_valid=0; instr_id=0; pc_id=0; valid_id=0; branch_count=0; FSM=BOOT. This overrides branch and stall, including mid-redirect or mid-halt.

Configuration
REQ-029 The block SHALL, with macro BRANCH_STATS_EN defined, increment branch_count on every edge with branch=1, saturating at 16'hFFFF.
REQ-030 The block SHALL, without BRANCH_STATS_EN, tie branch_count to 0 and keep the port present.

Structure
REQ-031 The block SHALL take PC_W, INSTR_W, HALT_WORD defaults and the FSM state enum from shared package nids_cpu_pkg.
REQ-032 The block SHALL place next-PC selection (hold, increment-with-wrap, redirect) in sub-module fetch_pc_gen.

Verification
REQ-033 The bench SHALL cover: rst then free-run, memory holding word k at address k -> pc_id/instr_id = 0,1,2,... with valid_id=1 from cycle 2.
REQ-034 The bench SHALL cover: branch=1, pc_mem_resolved=9'h040 at cycle T -> flush_* high in T only, valid_id low in T+1 and T+2, pc_id=0x040 in T+3.
REQ-035 The bench SHALL cover: stall held 3 cycles with branch asserted in the second -> redirect taken, stall ignored that edge, pc_id=target 3 cycles later.
REQ-036 The bench SHALL cover: P=511 running -> next imem_addr=0, pc_id sequence 510, 511, 0.
REQ-037 The bench SHALL cover: HALT_WORD at address 5 -> pc_id=5 valid once, then halted=1 and valid_id=0; a later branch to 0x010 resumes with pc_id=0x010.
REQ-038 The bench SHALL cover: with BRANCH_STATS_EN, 3 branches then rst mid-redirect -> branch_count=3, then 0, and FSM=BOOT.

Source files
------------

// File: rtl/nids_cpu_pkg.sv
// Shared CPU front-end definitions: datapath width defaults, halt encoding,
// fetch FSM states and next-PC selector codes.
package nids_cpu_pkg;

  localparam int          PC_W_DEF      = 9;
  localparam int          INSTR_W_DEF   = 32;
  localparam logic [31:0] HALT_WORD_DEF = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_e;

  typedef enum logic [1:0] {
    PC_HOLD     = 2'd0,
    PC_INC      = 2'd1,
    PC_REDIRECT = 2'd2
  } pc_sel_e;

endpackage

// File: rtl/fetch_pc_gen.sv
// Next-PC selection for the fetch stage: hold, sequential increment
// (wrapping naturally at 2^PC_W) or redirect to a resolved branch target.
module fetch_pc_gen
  import nids_cpu_pkg::*;
#(
  parameter int PC_W = PC_W_DEF
) (
  input  logic [PC_W-1:0] pc,
  input  logic [1:0]      sel,
  input  logic [PC_W-1:0] target,
  output logic [PC_W-1:0] pc_next
);

  localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

  always_comb begin
    pc_next = pc;
    case (sel)
      PC_INC:      pc_next = pc + PC_ONE;
      PC_REDIRECT: pc_next = target;
      default:     pc_next = pc;
    endcase
  end

endmodule

// File: rtl/fetch_redirect_unit.sv
// Instruction fetch with IF/ID register, branch redirect/flush, halt-word
// detection. Define BRANCH_STATS_EN to enable the taken-branch counter.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_BOOT | first cycle after reset, issues fetch of address 0
// ST_RUN  | sequential fetch, IF/ID register advances unless stalled
// ST_HALT | halt word delivered; PC frozen, memory idle until a branch
module fetch_redirect_unit
  import nids_cpu_pkg::*;
#(
  parameter int                 PC_W      = PC_W_DEF,
  parameter int                 INSTR_W   = INSTR_W_DEF,
  parameter logic [INSTR_W-1:0] HALT_WORD = INSTR_W'(HALT_WORD_DEF)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               branch,
  input  logic [PC_W-1:0]    pc_mem_resolved,
  output logic [PC_W-1:0]    imem_addr,
  output logic               imem_en,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instr_id,
  output logic [PC_W-1:0]    pc_id,
  output logic               valid_id,
  output logic               flush_ifid,
  output logic               flush_idex,
  output logic               flush_exmem,
  output logic               halted,
  output logic [15:0]        branch_count
);

  fetch_state_e        state, state_nxt;
  pc_sel_e             pc_sel;
  logic [PC_W-1:0]     p, p_nxt;
  logic [PC_W-1:0]     pc_f, pc_f_nxt;
  logic                f_valid, f_valid_nxt;
  logic [INSTR_W-1:0]  instr_nxt;
  logic [PC_W-1:0]     pc_id_nxt;
  logic                valid_nxt;

  fetch_pc_gen #(.PC_W(PC_W)) u_pc_gen (
    .pc      (p),
    .sel     (pc_sel),
    .target  (pc_mem_resolved),
    .pc_next (p_nxt)
  );

  assign imem_addr   = p;
  assign imem_en     = branch | (~stall & (state != ST_HALT));
  assign flush_ifid  = branch;
  assign flush_idex  = branch;
  assign flush_exmem = branch;
  assign halted      = (state == ST_HALT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_BOOT;
      p        <= '0;
      pc_f     <= '0;
      f_valid  <= 1'b0;
      instr_id <= '0;
      pc_id    <= '0;
      valid_id <= 1'b0;
    end else begin
      state    <= state_nxt;
      p        <= p_nxt;
      pc_f     <= pc_f_nxt;
      f_valid  <= f_valid_nxt;
      instr_id <= instr_nxt;
      pc_id    <= pc_id_nxt;
      valid_id <= valid_nxt;
    end
  end

  // Priority: branch redirect, then stall hold, then per-state behaviour.
  always_comb begin
    state_nxt   = state;
    pc_sel      = PC_HOLD;
    pc_f_nxt    = pc_f;
    f_valid_nxt = f_valid;
    instr_nxt   = instr_id;
    pc_id_nxt   = pc_id;
    valid_nxt   = valid_id;
    if (branch) begin
      pc_sel      = PC_REDIRECT;
      f_valid_nxt = 1'b0;
      valid_nxt   = 1'b0;
      state_nxt   = ST_RUN;
    end else if (!stall) begin
      case (state)
        ST_BOOT: begin
          pc_sel      = PC_INC;
          pc_f_nxt    = '0;
          f_valid_nxt = 1'b1;
          state_nxt   = ST_RUN;
        end
        ST_RUN: begin
          pc_sel      = PC_INC;
          pc_f_nxt    = p;
          f_valid_nxt = 1'b1;
          instr_nxt   = imem_rdata;
          pc_id_nxt   = pc_f;
          valid_nxt   = f_valid;
          // The halt word itself is still delivered to decode on this edge.
          if (f_valid && (imem_rdata == HALT_WORD)) state_nxt = ST_HALT;
        end
        ST_HALT: begin
          valid_nxt = 1'b0;
        end
        default: begin
          state_nxt = ST_BOOT;
        end
      endcase
    end
  end

`ifdef BRANCH_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      branch_count <= '0;
    end else if (branch && (branch_count != 16'hFFFF)) begin
      branch_count <= branch_count + 16'd1;
    end
  end
`else
  assign branch_count = '0;
`endif

endmodule

// File: tb/tb_fetch_redirect_unit.sv
// Self-checking bench for fetch_redirect_unit: directed vector table, corner
// sequences (halt, stats/reset) and random traffic against a queue-based model.
module tb_fetch_redirect_unit;

  localparam logic [31:0] HALT = 32'hFFFF_FFFF;
`ifdef BRANCH_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        branch = 1'b0;
  logic [8:0]  pc_mem_resolved = '0;
  logic [8:0]  imem_addr;
  logic        imem_en;
  logic [31:0] imem_rdata = '0;
  logic [31:0] instr_id;
  logic [8:0]  pc_id;
  logic        valid_id;
  logic        flush_ifid, flush_idex, flush_exmem;
  logic        halted;
  logic [15:0] branch_count;

  int checks = 0;
  int failures = 0;

  logic [31:0] mem [512];

  fetch_redirect_unit dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .branch          (branch),
    .pc_mem_resolved (pc_mem_resolved),
    .imem_addr       (imem_addr),
    .imem_en         (imem_en),
    .imem_rdata      (imem_rdata),
    .instr_id        (instr_id),
    .pc_id           (pc_id),
    .valid_id        (valid_id),
    .flush_ifid      (flush_ifid),
    .flush_idex      (flush_idex),
    .flush_exmem     (flush_exmem),
    .halted          (halted),
    .branch_count    (branch_count)
  );

  always #5 clk = ~clk;

  // Synchronous-read instruction memory that holds its output when disabled.
  always @(posedge clk) if (imem_en) imem_rdata <= mem[imem_addr];

  // Reference model: a queue of issued-but-undelivered fetch addresses.
  int          m_next;
  int          m_q[$];
  bit          m_vld;
  int          m_pc;
  logic [31:0] m_instr;
  bit          m_halt;
  bit          m_boot;
  int          m_cnt;

  task automatic model_step(input bit r, input bit s, input bit b, input int t);
    int a;
    if (r) begin
      m_next = 0; m_q.delete(); m_vld = 0; m_pc = 0; m_instr = '0;
      m_boot = 1; m_halt = 0; m_cnt = 0;
    end else if (b) begin
      m_next = t; m_q.delete(); m_vld = 0; m_halt = 0; m_boot = 0;
      if (STATS && m_cnt < 65535) m_cnt++;
    end else if (!s) begin
      if (m_boot) begin
        m_q.push_back(m_next);
        m_next = (m_next + 1) % 512;
        m_boot = 0;
      end else if (m_halt) begin
        m_vld = 0;
      end else begin
        if (m_q.size() > 0) begin
          a = m_q.pop_front();
          m_vld = 1; m_pc = a; m_instr = mem[a];
          if (mem[a] == HALT) m_halt = 1;
        end else begin
          m_vld = 0;
        end
        m_q.push_back(m_next);
        m_next = (m_next + 1) % 512;
      end
    end
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: drive, check combinational outputs, edge, check registers.
  task automatic cycle(input bit r, input bit s, input bit b, input int t);
    rst = r; stall = s; branch = b; pc_mem_resolved = t[8:0];
    #2;
    if (!r) begin
      chk("imem_en", imem_en, m_halt ? b : (b | !s));
      chk("flush_ifid", flush_ifid, b);
      chk("flush_idex", flush_idex, b);
      chk("flush_exmem", flush_exmem, b);
    end
    @(posedge clk);
    model_step(r, s, b, t);
    #1;
    chk("valid_id", valid_id, m_vld);
    chk("halted", halted, m_halt);
    chk("imem_addr", imem_addr, m_next);
    chk("branch_count", branch_count, m_cnt);
    if (m_vld) begin
      chk("pc_id", pc_id, m_pc);
      chk("instr_id", instr_id, m_instr);
    end
  endtask

  typedef struct {
    bit r; bit s; bit b; int t;
    bit v; int pc; int addr;
  } vec_t;

  vec_t tbl[$];

  initial begin
    #1ms;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 512; k++) mem[k] = k;

    // free run, redirect latency, stall+branch, PC wrap
    tbl.push_back('{1, 0, 0, 0,     0, 0,     0});
    tbl.push_back('{0, 0, 0, 0,     0, 0,     1});
    tbl.push_back('{0, 0, 0, 0,     1, 0,     2});
    tbl.push_back('{0, 0, 0, 0,     1, 1,     3});
    tbl.push_back('{0, 0, 0, 0,     1, 2,     4});
    tbl.push_back('{0, 0, 0, 0,     1, 3,     5});
    tbl.push_back('{0, 0, 1, 'h40,  0, 0,     'h40});
    tbl.push_back('{0, 0, 0, 0,     0, 0,     'h41});
    tbl.push_back('{0, 0, 0, 0,     1, 'h40,  'h42});
    tbl.push_back('{0, 0, 0, 0,     1, 'h41,  'h43});
    tbl.push_back('{0, 1, 0, 0,     1, 'h41,  'h43});
    tbl.push_back('{0, 1, 1, 'h80,  0, 0,     'h80});
    tbl.push_back('{0, 1, 0, 0,     0, 0,     'h80});
    tbl.push_back('{0, 0, 0, 0,     0, 0,     'h81});
    tbl.push_back('{0, 0, 0, 0,     1, 'h80,  'h82});
    tbl.push_back('{0, 0, 1, 510,   0, 0,     510});
    tbl.push_back('{0, 0, 0, 0,     0, 0,     511});
    tbl.push_back('{0, 0, 0, 0,     1, 510,   0});
    tbl.push_back('{0, 0, 0, 0,     1, 511,   1});
    tbl.push_back('{0, 0, 0, 0,     1, 0,     2});

    #1;
    for (int i = 0; i < tbl.size(); i++) begin
      cycle(tbl[i].r, tbl[i].s, tbl[i].b, tbl[i].t);
      chk($sformatf("tbl%0d_valid", i), valid_id, tbl[i].v);
      chk($sformatf("tbl%0d_addr", i), imem_addr, tbl[i].addr);
      if (tbl[i].v) begin
        chk($sformatf("tbl%0d_pc", i), pc_id, tbl[i].pc);
        chk($sformatf("tbl%0d_instr", i), instr_id, tbl[i].pc);
      end
    end

    // halt word at address 5, then resume by branch
    mem[5] = HALT;
    cycle(1, 0, 0, 0);
    cycle(0, 0, 0, 0);
    for (int i = 0; i < 6; i++) cycle(0, 0, 0, 0);
    chk("halt_pc", pc_id, 5);
    chk("halt_valid", valid_id, 1);
    chk("halt_instr", instr_id, HALT);
    chk("halt_flag", halted, 1);
    cycle(0, 0, 0, 0);
    chk("halted_valid", valid_id, 0);
    chk("halted_flag", halted, 1);
    chk("halted_en", imem_en, 0);
    chk("halted_addr", imem_addr, 7);
    cycle(0, 0, 0, 0);
    chk("halted_addr2", imem_addr, 7);
    cycle(0, 0, 1, 'h10);
    chk("resume_halted", halted, 0);
    cycle(0, 0, 0, 0);
    chk("resume_v1", valid_id, 0);
    cycle(0, 0, 0, 0);
    chk("resume_valid", valid_id, 1);
    chk("resume_pc", pc_id, 'h10);
    mem[5] = 5;

    // branch statistics and reset during a redirect
    cycle(1, 0, 0, 0);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 1, 'h20);
    cycle(0, 0, 1, 'h30);
    cycle(0, 0, 1, 'h40);
    chk("stats_count3", branch_count, STATS ? 3 : 0);
    cycle(1, 0, 1, 'h50);
    chk("stats_rst_count", branch_count, 0);
    chk("stats_rst_addr", imem_addr, 0);
    chk("stats_rst_valid", valid_id, 0);
    cycle(0, 0, 0, 0);
    chk("boot_addr", imem_addr, 1);
    chk("boot_valid", valid_id, 0);
    cycle(0, 0, 0, 0);
    chk("boot_first_pc", pc_id, 0);
    chk("boot_first_valid", valid_id, 1);

    // random traffic with sprinkled halt words
    for (int k = 0; k < 512; k++)
      mem[k] = ($urandom_range(0, 15) == 0) ? HALT : $urandom;
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 99) == 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 7) == 0, int'($urandom_range(0, 511)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
